map_ctrl_tx: RTL

- Initiator side of the mapper-control toggle handshake.
- Takes mapper-select commands from the host register/SPI side in the `clk` domain and drives `map_ctrl`/`map_ctrl_req` toward the mapper multiplexer, which samples on M2.
- Waits for the returned `map_ctrl_ack` and reports completion or timeout.
- Holds one pending command, so the host can queue the next select while the current one is in flight.

---
 rtl/map_ctrl_pkg.sv | 17 +
 rtl/sync_bit.sv | 26 ++
 rtl/map_ctrl_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/map_ctrl_pkg.sv
// Shared definitions for the mapper-control toggle handshake: control-word field
// layout and the initiator FSM state encoding.
package map_ctrl_pkg;

  localparam int unsigned CTRL_BITS = 24;
  localparam int unsigned SEL_LSB   = 0;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned ARGS_LSB  = 5;
  localparam int unsigned ARGS_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } ctrl_state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/map_ctrl_tx.sv
// Initiator side of the mapper-control toggle handshake: issues control words with a
// request toggle, waits for the synchronized ack, and holds one pending command.
module map_ctrl_tx #(
  parameter int unsigned CTRL_BITS      = 24,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CTRL_BITS-1:0] cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [CTRL_BITS-1:0] map_ctrl,
  output logic                 map_ctrl_req,
  input  logic                 map_ctrl_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  import map_ctrl_pkg::*;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SYNC_STAGES);

  ctrl_state_t          state_q, state_d;
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic [CTRL_BITS-1:0] slot_q, slot_d;
  logic                 slot_full_q, slot_full_d;
  logic                 req_q, req_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 recover_q, recover_d;
  logic [SET_W-1:0]     settle_q;
  logic                 ack_s;
  logic                 accept;
  logic                 settled;
  logic                 match;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (map_ctrl_ack),
    .q    (ack_s)
  );

  assign accept  = cmd_valid && !slot_full_q;
  assign match   = (ack_s == req_q);
  // The synchronizer restarts at 0 on reset; issuing is held off until it has
  // refilled so a still-high ack from before reset is seen as outstanding.
  assign settled = (settle_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      req_q       <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      recover_q   <= 1'b0;
      settle_q    <= SETTLE_INIT;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      recover_q   <= recover_d;
      if (!settled) settle_q <= settle_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    recover_d   = recover_q;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (settled && !match) begin
          state_d   = WAIT;
          recover_d = 1'b1;
          cnt_d     = '0;
          if (accept) begin
            slot_d      = cmd_data;
            slot_full_d = 1'b1;
          end
        end else if (settled && slot_full_q) begin
          ctrl_d      = slot_q;
          req_d       = ~req_q;
          slot_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = WAIT;
        end else if (settled && accept) begin
          ctrl_d  = cmd_data;
          req_d   = ~req_q;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (accept) begin
          slot_d      = cmd_data;
          slot_full_d = 1'b1;
        end
      end
      WAIT, STALL: begin
        if (match) begin
          done      = !recover_q;
          recover_d = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (state_q == WAIT) begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = STALL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (accept) begin
          slot_d      = cmd_data;
          slot_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready    = !slot_full_q;
  assign map_ctrl     = ctrl_q;
  assign map_ctrl_req = req_q;
  assign busy         = (state_q != IDLE) || slot_full_q;
  assign timeout      = timeout_q;

endmodule
